// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks.
package fifo_pkg;

    // Default data word width; matches the FIFO data width.
    localparam int DSIZE_DEFAULT = 8;

    // Default width of the pop and transfer counters.
    localparam int CNTW_DEFAULT = 16;

    // Skid buffer occupancy. The encoding equals the number of held words,
    // so the state doubles as the occupancy output.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus the outgoing valid/ready stream.
//
// Handshake: rinc pops the FIFO head on the rclk edge where it is high, and
// it is only ever high while rempty is low. A stream word moves on every
// rclk edge where m_valid and m_ready are both high. Once m_valid rises,
// m_valid and m_data stay unchanged until that edge. m_ready may change
// freely and never feeds back into rinc.
interface fifo_rd_stream_if #(
    parameter int DSIZE = fifo_pkg::DSIZE_DEFAULT
);
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;

    // The stream block side: pops the FIFO and sources the stream.
    modport master (
        output rinc,
        input  rdata,
        input  rempty,
        output m_valid,
        output m_data,
        input  m_ready
    );

    // The environment side: the FIFO read port and the stream consumer.
    modport slave (
        input  rinc,
        output rdata,
        output rempty,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry skid buffer with a registered valid/data stream output.
// The head register drives m_data; the skid register holds the second word.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output occ_e             occ
);

    occ_e             state_q;
    logic             valid_q;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] skid_q;
    logic             xfer;

    assign xfer    = valid_q & m_ready;
    assign m_valid = valid_q;
    assign m_data  = head_q;
    assign occ     = state_q;

    // Occupancy FSM; valid and both data registers move with the state so
    // that words always leave in the order they were pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
            valid_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_q  <= push_data;
                        valid_q <= 1'b1;
                        state_q <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && !xfer) begin
                        skid_q  <= push_data;
                        state_q <= OCC_TWO;
                    end else if (!push && xfer) begin
                        valid_q <= 1'b0;
                        state_q <= OCC_EMPTY;
                    end else if (push && xfer) begin
                        // Head leaves and the new word takes its place.
                        head_q <= push_data;
                    end
                end
                OCC_TWO: begin
                    // The pop gating keeps push low here.
                    if (xfer) begin
                        head_q  <= skid_q;
                        state_q <= OCC_ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO: pops the FIFO into a two-entry
// skid buffer, presents a registered valid/ready stream and counts words.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT,
    parameter int CNTW  = CNTW_DEFAULT
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rd_en,
    fifo_rd_stream_if.master     bus,
    output logic [1:0]           occ,
    output logic [CNTW-1:0]      pop_cnt,
    output logic [CNTW-1:0]      xfer_cnt,
    output logic                 idle
);

    occ_e            occ_st;
    logic            pop;
    logic            xfer;
    logic [CNTW-1:0] pop_cnt_q;
    logic [CNTW-1:0] pop_cnt_d;
    logic [CNTW-1:0] xfer_cnt_q;
    logic [CNTW-1:0] xfer_cnt_d;

    // Pop only when the buffer has room; reset gates it immediately.
    // m_ready is deliberately absent so no ready-to-pop path exists.
    assign pop      = rrst_n & rd_en & ~bus.rempty & (occ_st != OCC_TWO);
    assign bus.rinc = pop;
    assign xfer     = bus.m_valid & bus.m_ready;

    rd_skid_buf #(
        .DSIZE (DSIZE)
    ) u_skid (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .push      (pop),
        .push_data (bus.rdata),
        .m_valid   (bus.m_valid),
        .m_data    (bus.m_data),
        .m_ready   (bus.m_ready),
        .occ       (occ_st)
    );

    // Next counter values; both wrap freely.
    always_comb begin
        pop_cnt_d  = pop_cnt_q;
        xfer_cnt_d = xfer_cnt_q;
        if (pop) begin
            pop_cnt_d = pop_cnt_q + CNTW'(1);
        end
        if (xfer) begin
            xfer_cnt_d = xfer_cnt_q + CNTW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pop_cnt_q  <= '0;
            xfer_cnt_q <= '0;
        end else begin
            pop_cnt_q  <= pop_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign occ      = occ_st;
    assign pop_cnt  = pop_cnt_q;
    assign xfer_cnt = xfer_cnt_q;
    assign idle     = (occ_st == OCC_EMPTY) & bus.rempty;

endmodule
